// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the 5-stage core datapath and pipe_hazard_ctrl.
// The core side uses the master modport. The control block uses the slave modport.
interface pipe_hazard_ctrl_if;
  logic        load_use_stall;
  logic        branch_taken_ex;
  logic        jump_id;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_ack;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        bubble_q;
  logic        bus_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output load_use_stall, branch_taken_ex, jump_id, imem_ack, dmem_req, dmem_ack,
    input  pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
    input  bubble_q, bus_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  load_use_stall, branch_taken_ex, jump_id, imem_ack, dmem_req, dmem_ack,
    output pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, memwb_flush,
    output bubble_q, bus_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/PC-select control with a data-memory wait timeout.
// Define PIPE_HAZARD_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    hz
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DWAIT = 2'd1;
  localparam logic [1:0] ERR   = 2'd2;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             bubble_q;

  logic in_err, dwait_c, luse_c, br_c, jmp_c, fw_c;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0] pc_sel;

  // One-hot view of which priority case is active this cycle.
  always_comb begin
    in_err  = (state_q == ERR);
    dwait_c = !in_err && hz.dmem_req && !hz.dmem_ack;
    luse_c  = !in_err && !dwait_c && hz.load_use_stall;
    br_c    = !in_err && !dwait_c && !luse_c && hz.branch_taken_ex;
    jmp_c   = !in_err && !dwait_c && !luse_c && !br_c && hz.jump_id;
    fw_c    = !in_err && !dwait_c && !luse_c && !br_c && !jmp_c && !hz.imem_ack;
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_sel      = 2'b00;
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
    end else if (in_err) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
    end else if (dwait_c) begin
      {pc_en, ifid_en, idex_en, exmem_en} = '0;
      memwb_flush = 1'b1;
    end else if (luse_c) begin
      {pc_en, ifid_en, idex_en} = '0;
      exmem_flush = 1'b1;
    end else if (br_c) begin
      pc_sel     = 2'b01;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (jmp_c) begin
      pc_sel     = 2'b10;
      ifid_flush = 1'b1;
    end else if (fw_c) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // wait_cnt holds the number of wait cycles already completed, so the
  // incremented value reaching MEM_TIMEOUT ends the last allowed wait cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ack) begin
          wait_cnt_d = CNT_W'(1);
          if (MEM_TIMEOUT <= 1) begin
            state_d   = ERR;
            bus_err_d = 1'b1;
          end else begin
            state_d = DWAIT;
          end
        end
      end
      DWAIT: begin
        if (!hz.dmem_req || hz.dmem_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_d >= TIMEOUT_C) begin
            state_d   = ERR;
            bus_err_d = 1'b1;
          end
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
      bubble_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
      bubble_q   <= luse_c;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Counters only step on live cases, so they hold automatically in ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((dwait_c || luse_c) && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((br_c || jmp_c) && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

  assign hz.pc_en       = pc_en;
  assign hz.pc_sel      = pc_sel;
  assign hz.ifid_en     = ifid_en;
  assign hz.idex_en     = idex_en;
  assign hz.exmem_en    = exmem_en;
  assign hz.memwb_en    = memwb_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.memwb_flush = memwb_flush;
  assign hz.bubble_q    = bubble_q;
  assign hz.bus_err     = bus_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4).
// Control word order: {pc_en, pc_sel[1:0], ifid/idex/exmem/memwb_en, ifid/idex/exmem/memwb_flush}.
module tb_pipe_hazard_ctrl;

  localparam logic [10:0] C_NORM = 11'b1_00_1111_0000;
  localparam logic [10:0] C_RST  = 11'b0_00_0000_1111;
  localparam logic [10:0] C_ERR  = 11'b0_00_0000_0000;
  localparam logic [10:0] C_DW   = 11'b0_00_0001_0001;
  localparam logic [10:0] C_LUSE = 11'b0_00_0011_0010;
  localparam logic [10:0] C_BR   = 11'b1_01_1111_1100;
  localparam logic [10:0] C_JMP  = 11'b1_10_1111_1000;
  localparam logic [10:0] C_FW   = 11'b0_00_1111_1000;

  logic clk = 1'b0;
  logic rst;
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  logic [10:0] ctl;
  assign ctl = {hz.pc_en, hz.pc_sel, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lu, input logic br, input logic jmp,
                       input logic ia, input logic dreq, input logic dack);
    hz.load_use_stall  = lu;
    hz.branch_taken_ex = br;
    hz.jump_id         = jmp;
    hz.imem_ack        = ia;
    hz.dmem_req        = dreq;
    hz.dmem_ack        = dack;
  endtask

  // Check the combinational control word, tally expected counter steps, advance a cycle.
  task automatic run_cycle(input string tag, input logic [10:0] exp);
    #1;
    check_eq(tag, 32'(ctl), 32'(exp));
    if (exp == C_DW || exp == C_LUSE) exp_stall++;
    if (exp == C_BR || exp == C_JMP)  exp_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
`ifdef PIPE_HAZARD_PERF_EN
    check_eq({tag, "_stall"}, hz.stall_cnt, 32'(exp_stall));
    check_eq({tag, "_flush"}, hz.flush_cnt, 32'(exp_flush));
`else
    check_eq({tag, "_stall"}, hz.stall_cnt, 32'd0);
    check_eq({tag, "_flush"}, hz.flush_cnt, 32'd0);
`endif
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 0);
    #1;
    check_eq("rst_ctl", 32'(ctl), 32'(C_RST));
    @(posedge clk);
    #1;
    check_eq("rst_bubble", 32'(hz.bubble_q), 32'd0);
    check_eq("rst_buserr", 32'(hz.bus_err), 32'd0);
    check_counters("rst");
    rst = 1'b0;
    run_cycle("idle", C_NORM);

    drive(1, 0, 0, 1, 0, 0); run_cycle("luse", C_LUSE);
    drive(0, 0, 0, 1, 0, 0);
    check_eq("bubble_set", 32'(hz.bubble_q), 32'd1);
    run_cycle("post_luse", C_NORM);
    check_eq("bubble_clr", 32'(hz.bubble_q), 32'd0);

    drive(0, 1, 1, 0, 0, 0); run_cycle("br_over_jmp", C_BR);
    drive(0, 0, 1, 0, 0, 0); run_cycle("jmp_over_fw", C_JMP);
    drive(0, 0, 0, 0, 0, 0); run_cycle("fetch_wait", C_FW);
    drive(1, 1, 0, 1, 0, 0); run_cycle("luse_over_br", C_LUSE);
    drive(0, 0, 0, 1, 1, 1);
    check_eq("bubble_br", 32'(hz.bubble_q), 32'd1);
    run_cycle("dmem_same_ack", C_NORM);

    // Three-cycle wait, first wait cycle also carries a masked load-use.
    drive(1, 0, 0, 1, 1, 0); run_cycle("dwait_over_luse", C_DW);
    check_eq("bubble_masked", 32'(hz.bubble_q), 32'd0);
    drive(0, 0, 0, 1, 1, 0);
    run_cycle("dwait2", C_DW);
    run_cycle("dwait3", C_DW);
    drive(0, 0, 0, 1, 1, 1); run_cycle("dwait_ack", C_NORM);
    check_eq("no_err_3wait", 32'(hz.bus_err), 32'd0);
    check_counters("after_wait");

    // Reset in the middle of a wait must clear the wait count.
    drive(0, 0, 0, 1, 1, 0);
    run_cycle("pre_rst_w1", C_DW);
    run_cycle("pre_rst_w2", C_DW);
    rst = 1'b1;
    run_cycle("rst_mid_dwait", C_RST);
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    check_counters("post_rst");
    for (int i = 0; i < 3; i++) run_cycle("post_rst_wait", C_DW);
    drive(0, 0, 0, 1, 1, 1); run_cycle("post_rst_ack", C_NORM);
    check_eq("post_rst_noerr", 32'(hz.bus_err), 32'd0);

    // Timeout after exactly four wait cycles.
    drive(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("buserr_pre", 32'(hz.bus_err), 32'd0);
      run_cycle("to_wait", C_DW);
    end
    check_eq("buserr_set", 32'(hz.bus_err), 32'd1);
    run_cycle("err", C_ERR);
    drive(1, 1, 1, 1, 1, 1); run_cycle("err_frozen", C_ERR);
    check_eq("buserr_sticky", 32'(hz.bus_err), 32'd1);
    check_eq("err_bubble", 32'(hz.bubble_q), 32'd0);
    check_counters("err");

    rst = 1'b1;
    drive(0, 0, 0, 1, 0, 0);
    run_cycle("rst_err", C_RST);
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    check_eq("buserr_clr", 32'(hz.bus_err), 32'd0);
    run_cycle("recover", C_NORM);
    drive(0, 1, 0, 1, 0, 0); run_cycle("recover_br", C_BR);
    check_counters("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
